capture_trigger: RTL and testbench

- Sample-acquisition front end sitting directly upstream of the FIFO write side in the oscilloscope datapath.
- Watches the ADC sample stream for an edge trigger and writes a programmed number of samples into the FIFO write port.
- Drives the write-pointer increment and the memory write data, and honours the FIFO-full flag.
- Runs entirely in the ADC/write clock domain.

---
 rtl/capture_trigger_if.sv | 28 ++
 rtl/capture_trigger.sv | 222 ++++++++++++++++++++++
 tb/tb_capture_trigger.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/capture_trigger_if.sv
// Sample-stream / FIFO-write bundle for capture_trigger.
// The slave modport is the capture block. The master modport is the
// ADC source together with the FIFO write side.
interface capture_trigger_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] sample_i;
    logic              sample_vld_i;
    logic              fifo_full_i;
    logic              wr_en_o;
    logic [DATA_W-1:0] wr_data_o;

    modport slave (
        input  sample_i,
        input  sample_vld_i,
        input  fifo_full_i,
        output wr_en_o,
        output wr_data_o
    );

    modport master (
        output sample_i,
        output sample_vld_i,
        output fifo_full_i,
        input  wr_en_o,
        input  wr_data_o
    );
endinterface

// File: rtl/capture_trigger.sv
// Edge-triggered acquisition front end that feeds the FIFO write port.
// The block waits for an edge trigger on the ADC stream. It then writes a
// programmed number of samples, with a latency of one cycle per write.
// Optional decimation is enabled by the macro CAPTURE_TRIGGER_DECIM_EN.
module capture_trigger #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 9
) (
    input  logic                clk_i,
    input  logic                rst_i,
    capture_trigger_if.slave    bus,
    input  logic                arm_i,
    input  logic                abort_i,
    input  logic [DATA_W-1:0]   level_i,
    input  logic                slope_i,
    input  logic [CNT_W-1:0]    capture_len_i,
`ifdef CAPTURE_TRIGGER_DECIM_EN
    input  logic [7:0]          decim_i,
`endif
    output logic                busy_o,
    output logic                trig_o,
    output logic                done_o,
    output logic                overflow_o
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARMED   = 3'd1,
        ST_WAIT    = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] level_q, level_d;
    logic              slope_q, slope_d;
    logic [CNT_W-1:0]  len_q, len_d;
    logic [CNT_W:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0] prev_q, prev_d;
    logic              prev_vld_q, prev_vld_d;
    logic              wr_en_q, wr_en_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              trig_q, trig_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              ovf_q, ovf_d;

    logic              take_s;
    logic              fire_s;
    logic              cap_s;
    logic              arm_now_s;
    logic [CNT_W:0]    target_s;
    logic [CNT_W:0]    cnt_inc_s;

`ifdef CAPTURE_TRIGGER_DECIM_EN
    logic [7:0] decim_q, decim_d;
    logic [7:0] dcnt_q, dcnt_d;
    assign take_s = bus.sample_vld_i && (dcnt_q == decim_q);
`else
    assign take_s = bus.sample_vld_i;
`endif

    // A programmed length of 0 stands for the full 2^CNT_W samples.
    assign target_s  = (len_q == {CNT_W{1'b0}}) ? {1'b1, {CNT_W{1'b0}}} : {1'b0, len_q};
    assign cnt_inc_s = cnt_q + {{CNT_W{1'b0}}, 1'b1};
    assign fire_s    = prev_vld_q && (slope_q ?
                           ((prev_q < level_q) && (bus.sample_i >= level_q)) :
                           ((prev_q > level_q) && (bus.sample_i <= level_q)));

    // Next-state and output decode; abort overrides every other event.
    always_comb begin
        state_d    = state_q;
        level_d    = level_q;
        slope_d    = slope_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        prev_d     = prev_q;
        prev_vld_d = prev_vld_q;
        wr_en_d    = 1'b0;
        wr_data_d  = wr_data_q;
        trig_d     = 1'b0;
        ovf_d      = ovf_q;
        cap_s      = 1'b0;
        arm_now_s  = 1'b0;

        if (abort_i) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (arm_i) begin
                        arm_now_s  = 1'b1;
                        level_d    = level_i;
                        slope_d    = slope_i;
                        len_d      = capture_len_i;
                        ovf_d      = 1'b0;
                        prev_vld_d = 1'b0;
                        state_d    = ST_ARMED;
                    end else begin
                        state_d = state_q;
                    end
                end
                ST_ARMED: begin
                    if (take_s) begin
                        prev_d     = bus.sample_i;
                        prev_vld_d = 1'b1;
                        state_d    = ST_WAIT;
                    end else begin
                        state_d = ST_ARMED;
                    end
                end
                ST_WAIT: begin
                    if (take_s && fire_s) begin
                        trig_d  = 1'b1;
                        cap_s   = 1'b1;
                        cnt_d   = {{CNT_W{1'b0}}, 1'b1};
                        state_d = (target_s == {{CNT_W{1'b0}}, 1'b1}) ? ST_DONE : ST_CAPTURE;
                    end else if (take_s) begin
                        prev_d = bus.sample_i;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
                ST_CAPTURE: begin
                    if (take_s) begin
                        cap_s   = 1'b1;
                        cnt_d   = cnt_inc_s;
                        state_d = (cnt_inc_s == target_s) ? ST_DONE : ST_CAPTURE;
                    end else begin
                        state_d = ST_CAPTURE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        // A captured sample is dropped (and flagged) when the FIFO is full.
        if (cap_s && bus.fifo_full_i) begin
            ovf_d = 1'b1;
        end else if (cap_s) begin
            wr_en_d   = 1'b1;
            wr_data_d = bus.sample_i;
        end else begin
            wr_en_d = 1'b0;
        end

        busy_d = (state_d == ST_ARMED) || (state_d == ST_WAIT) || (state_d == ST_CAPTURE);
        done_d = (state_d == ST_DONE);
    end

`ifdef CAPTURE_TRIGGER_DECIM_EN
    // Decimation counter: restarted at arm, then advanced on every valid sample.
    always_comb begin
        decim_d = decim_q;
        dcnt_d  = dcnt_q;
        if (arm_now_s) begin
            decim_d = decim_i;
            dcnt_d  = 8'd0;
        end else if (bus.sample_vld_i && (dcnt_q == decim_q)) begin
            dcnt_d = 8'd0;
        end else if (bus.sample_vld_i) begin
            dcnt_d = dcnt_q + 8'd1;
        end else begin
            dcnt_d = dcnt_q;
        end
    end

    // Decimation registers.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            decim_q <= 8'd0;
            dcnt_q  <= 8'd0;
        end else begin
            decim_q <= decim_d;
            dcnt_q  <= dcnt_d;
        end
    end
`endif

    // State and registered-output update with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q    <= ST_IDLE;
            level_q    <= {DATA_W{1'b0}};
            slope_q    <= 1'b0;
            len_q      <= {CNT_W{1'b0}};
            cnt_q      <= {(CNT_W+1){1'b0}};
            prev_q     <= {DATA_W{1'b0}};
            prev_vld_q <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_data_q  <= {DATA_W{1'b0}};
            trig_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            level_q    <= level_d;
            slope_q    <= slope_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            prev_q     <= prev_d;
            prev_vld_q <= prev_vld_d;
            wr_en_q    <= wr_en_d;
            wr_data_q  <= wr_data_d;
            trig_q     <= trig_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            ovf_q      <= ovf_d;
        end
    end

    assign bus.wr_en_o   = wr_en_q;
    assign bus.wr_data_o = wr_data_q;
    assign busy_o        = busy_q;
    assign trig_o        = trig_q;
    assign done_o        = done_q;
    assign overflow_o    = ovf_q;

endmodule

// File: tb/tb_capture_trigger.sv
// Self-checking bench for capture_trigger: directed scenarios, then random traffic.
// Each cycle, the DUT outputs are compared with a behavioural model.
module tb_capture_trigger;

    logic       clk = 1'b0;
    logic       rst_i = 1'b0;
    logic       arm_i = 1'b0;
    logic       abort_i = 1'b0;
    logic [7:0] level_i = 8'd0;
    logic       slope_i = 1'b0;
    logic [8:0] capture_len_i = 9'd0;
    logic       busy_o, trig_o, done_o, overflow_o;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    capture_trigger_if #(.DATA_W(8)) bus ();

    capture_trigger #(.DATA_W(8), .CNT_W(9)) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .bus           (bus),
        .arm_i         (arm_i),
        .abort_i       (abort_i),
        .level_i       (level_i),
        .slope_i       (slope_i),
        .capture_len_i (capture_len_i),
`ifdef CAPTURE_TRIGGER_DECIM_EN
        .decim_i       (8'd0),
`endif
        .busy_o        (busy_o),
        .trig_o        (trig_o),
        .done_o        (done_o),
        .overflow_o    (overflow_o)
    );

    always #5 clk = ~clk;

    // Behavioural model. Phase: 0 idle, 1 armed, 2 waiting, 3 capturing, 4 done.
    int       m_phase = 0;
    int       m_remaining = 0;
    int       m_prev = 0;
    int       m_lvl = 0;
    bit       m_rise = 1'b0;
    bit       m_wr_en = 1'b0;
    int       m_wr_data = 0;
    bit       m_trig = 1'b0;
    bit       m_ovf = 1'b0;

    logic [7:0] wq[$];
    int         trig_cnt = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit crossed(input int p, input int c, input int l, input bit rise);
        if (rise) return (p < l) && (l <= c);
        else      return (c <= l) && (l < p);
    endfunction

    // Store one captured sample in the model.
    task automatic m_store(input int s, input bit full);
        m_remaining--;
        if (full) m_ovf = 1'b1;
        else begin
            m_wr_en   = 1'b1;
            m_wr_data = s;
        end
        m_phase = (m_remaining == 0) ? 4 : 3;
    endtask

    // Compare against the model, log writes, then advance the model for the coming edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("wr_en",    {15'd0, bus.wr_en_o},  {15'd0, m_wr_en});
            chk("wr_data",  {8'd0, bus.wr_data_o}, m_wr_data[15:0]);
            chk("trig",     {15'd0, trig_o},       {15'd0, m_trig});
            chk("busy",     {15'd0, busy_o},       {15'd0, (m_phase >= 1 && m_phase <= 3)});
            chk("done",     {15'd0, done_o},       {15'd0, (m_phase == 4)});
            chk("overflow", {15'd0, overflow_o},   {15'd0, m_ovf});
            if (bus.wr_en_o === 1'b1) wq.push_back(bus.wr_data_o);
            if (trig_o === 1'b1) trig_cnt++;
        end
        m_wr_en = 1'b0;
        m_trig  = 1'b0;
        if (!rst_i) begin
            m_phase = 0; m_wr_data = 0; m_ovf = 1'b0; m_remaining = 0; m_prev = 0;
        end else if (abort_i) begin
            m_phase = 0;
        end else begin
            case (m_phase)
                0, 4: if (arm_i) begin
                    m_lvl       = int'(level_i);
                    m_rise      = slope_i;
                    m_remaining = (capture_len_i == 9'd0) ? 512 : int'(capture_len_i);
                    m_ovf       = 1'b0;
                    m_phase     = 1;
                end
                1: if (bus.sample_vld_i) begin
                    m_prev  = int'(bus.sample_i);
                    m_phase = 2;
                end
                2: if (bus.sample_vld_i) begin
                    if (crossed(m_prev, int'(bus.sample_i), m_lvl, m_rise)) begin
                        m_trig = 1'b1;
                        m_store(int'(bus.sample_i), bus.fifo_full_i);
                    end else m_prev = int'(bus.sample_i);
                end
                3: if (bus.sample_vld_i) m_store(int'(bus.sample_i), bus.fifo_full_i);
                default: ;
            endcase
        end
    end

    // Apply one cycle of inputs shortly after the active edge.
    task automatic drive(input logic v, input logic [7:0] s, input logic f,
                         input logic a, input logic ab);
        @(posedge clk);
        #2;
        bus.sample_vld_i = v;
        bus.sample_i     = s;
        bus.fifo_full_i  = f;
        arm_i            = a;
        abort_i          = ab;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic arm(input logic [7:0] lvl, input logic slp, input logic [8:0] len);
        level_i = lvl; slope_i = slp; capture_len_i = len;
        drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        wq.delete();
        trig_cnt = 0;
    endtask

    task automatic smp(input logic [7:0] s);
        drive(1'b1, s, 1'b0, 1'b0, 1'b0);
    endtask

    // Rising trigger at 0x80, length 4.
    task automatic scenario_rise();
        logic [7:0] seq [7];
        seq = '{8'h10, 8'h70, 8'h90, 8'hA0, 8'hB0, 8'hC0, 8'hD0};
        arm(8'h80, 1'b1, 9'd4);
        foreach (seq[i]) smp(seq[i]);
        idle(3);
        chk("s1_nwr",  wq.size(), 16'd4);
        if (wq.size() == 4) begin
            chk("s1_d0", {8'd0, wq[0]}, 16'h90);
            chk("s1_d1", {8'd0, wq[1]}, 16'hA0);
            chk("s1_d2", {8'd0, wq[2]}, 16'hB0);
            chk("s1_d3", {8'd0, wq[3]}, 16'hC0);
        end
        chk("s1_trig", trig_cnt, 16'd1);
        chk("s1_done", {15'd0, done_o}, 16'd1);
        chk("s1_busy", {15'd0, busy_o}, 16'd0);
    endtask

    initial begin
        bus.sample_vld_i = 1'b0;
        bus.sample_i     = 8'h00;
        bus.fifo_full_i  = 1'b0;
        idle(3);
        rst_i = 1'b1;
        idle(1);
        chk_en = 1'b1;
        idle(1);
        chk("rst_busy", {15'd0, busy_o}, 16'd0);
        chk("rst_wr",   {15'd0, bus.wr_en_o}, 16'd0);

        scenario_rise();

        // Falling trigger fires when the sample equals the level.
        arm(8'h40, 1'b0, 9'd1);
        smp(8'h50); smp(8'h40);
        idle(3);
        chk("s2_nwr",  wq.size(), 16'd1);
        if (wq.size() == 1) chk("s2_d0", {8'd0, wq[0]}, 16'h40);
        chk("s2_done", {15'd0, done_o}, 16'd1);

        // A rising trigger where prev equals the level must not fire.
        arm(8'h40, 1'b1, 9'd1);
        smp(8'h40); smp(8'h40);
        idle(3);
        chk("s2b_trig", trig_cnt, 16'd0);
        chk("s2b_busy", {15'd0, busy_o}, 16'd1);
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        idle(2);

        // The FIFO is full on the second capture sample.
        arm(8'h80, 1'b1, 9'd3);
        smp(8'h10); smp(8'h90);
        drive(1'b1, 8'hA0, 1'b1, 1'b0, 1'b0);
        smp(8'hB0);
        idle(3);
        chk("s3_nwr", wq.size(), 16'd2);
        if (wq.size() == 2) chk("s3_d1", {8'd0, wq[1]}, 16'hB0);
        chk("s3_ovf",  {15'd0, overflow_o}, 16'd1);
        chk("s3_done", {15'd0, done_o}, 16'd1);

        // Valid only every third cycle during capture.
        arm(8'h80, 1'b1, 9'd4);
        smp(8'h10); smp(8'h90);
        for (int i = 0; i < 3; i++) begin
            idle(2);
            smp(8'hA0 + 8'(i));
        end
        idle(3);
        chk("s4_nwr", wq.size(), 16'd4);

        // Abort after two of eight samples, together with a valid sample.
        arm(8'h80, 1'b1, 9'd8);
        smp(8'h10); smp(8'h90); smp(8'hA0);
        drive(1'b1, 8'hB0, 1'b0, 1'b0, 1'b1);
        smp(8'hC0);
        idle(3);
        chk("s5_nwr",  wq.size(), 16'd2);
        chk("s5_busy", {15'd0, busy_o}, 16'd0);
        chk("s5_done", {15'd0, done_o}, 16'd0);

        // Reset in the middle of a capture, then run the rising scenario again.
        arm(8'h80, 1'b1, 9'd4);
        smp(8'h10); smp(8'h90); smp(8'hA0);
        rst_i = 1'b0;
        idle(1);
        idle(1);
        chk("s6_wr",   {15'd0, bus.wr_en_o}, 16'd0);
        chk("s6_data", {8'd0, bus.wr_data_o}, 16'd0);
        chk("s6_busy", {15'd0, busy_o}, 16'd0);
        chk("s6_trig", {15'd0, trig_o}, 16'd0);
        chk("s6_done", {15'd0, done_o}, 16'd0);
        chk("s6_ovf",  {15'd0, overflow_o}, 16'd0);
        rst_i = 1'b1;
        idle(1);
        scenario_rise();

        // Random traffic, checked by the model on every cycle.
        for (int i = 0; i < 4000; i++) begin
            level_i       = 8'($urandom);
            slope_i       = 1'($urandom);
            capture_len_i = ($urandom_range(0, 60) == 0) ? 9'd0 : 9'($urandom_range(1, 7));
            rst_i         = ($urandom_range(0, 499) != 0);
            drive(($urandom_range(0, 9) < 6), 8'($urandom),
                  ($urandom_range(0, 6) == 0), ($urandom_range(0, 19) == 0),
                  ($urandom_range(0, 149) == 0));
        end
        rst_i = 1'b1;
        idle(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
